ex_issue_stage: RTL and testbench

Execute-stage issue register of the pipelined datapath: it captures a decoded instruction from the ID stage, translates ALU op/funct into the 4-bit ALU control and 3-bit compare code, and drives the two operands of the 32-bit ALU directly downstream. Operands are forwarded from the MEM and WB stages. Stall and flush inputs from the hazard unit hold the stage or insert a bubble.

---
 rtl/ex_issue_if.sv | 57 +++++
 rtl/ex_issue_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_issue_stage.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_if.sv
// ex_issue_if
//   Bundles the ID-side instruction fields, hazard controls, forwarding
//   sources and ALU-side outputs of the EX issue register.
//   Modports:
//     master - ID/hazard/forwarding driver side; observes ALU operands
//     slave  - ex_issue_stage side; consumes ID fields, produces operands
interface ex_issue_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [2:0]        id_alu_op;
    logic [5:0]        id_funct;
    logic              id_alusrc;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_wr;
    logic              id_regwrite;
    logic              mem_regwrite;
    logic              wb_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [3:0]        alu_control;
    logic [2:0]        alu_comp;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_illegal;
    logic [REG_AW-1:0] ex_wr;
    logic [DATA_W-1:0] ex_store_data;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_alu_op, id_funct, id_alusrc, id_rs, id_rt, id_wr,
               id_regwrite, mem_regwrite, wb_regwrite, mem_rd, wb_rd,
               mem_result, wb_data,
        input  alu_src1, alu_src2, alu_control, alu_comp, ex_valid,
               ex_regwrite, ex_illegal, ex_wr, ex_store_data
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_alu_op, id_funct, id_alusrc, id_rs, id_rt, id_wr,
               id_regwrite, mem_regwrite, wb_regwrite, mem_rd, wb_rd,
               mem_result, wb_data,
        output alu_src1, alu_src2, alu_control, alu_comp, ex_valid,
               ex_regwrite, ex_illegal, ex_wr, ex_store_data
    );
endinterface

// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//   Execute-stage issue register. Decodes alu_op/funct into the 4-bit ALU
//   control and 3-bit compare code, registers the instruction, and drives
//   the ALU operands combinationally from the registered fields, with
//   optional MEM/WB forwarding.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (forces a bubble)
//     bus    - ex_issue_if.slave: ID fields, stall/flush, forwarding
//              sources in; alu_src1/2, alu_control, alu_comp, ex_* out
//   Build option:
//     EX_FWD_EN - when defined, MEM/WB forwarding muxes are present; when
//                 undefined, operands come only from latched register data
//                 and the hazard unit must stall on dependencies.
module ex_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    ex_issue_if.slave bus
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [2:0] CMP_LT  = 3'b000;
    localparam logic [2:0] CMP_LTU = 3'b101;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              alusrc;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wr;
        logic              regwrite;
        logic [3:0]        alu_control;
        logic [2:0]        comp;
        logic              illegal;
        logic              zext;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;

    logic [3:0] dec_ctrl;
    logic [2:0] dec_comp;
    logic       dec_illegal;
    logic       dec_zext;

    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_comp    = CMP_LT;
        dec_illegal = 1'b0;
        dec_zext    = 1'b0;
        case (bus.id_alu_op)
            3'b000: dec_ctrl = ALU_ADD;
            3'b001: dec_ctrl = ALU_SUB;
            3'b010: begin
                case (bus.id_funct)
                    6'h20: dec_ctrl = ALU_ADD;
                    6'h22: dec_ctrl = ALU_SUB;
                    6'h24: dec_ctrl = ALU_AND;
                    6'h25: dec_ctrl = ALU_OR;
                    6'h27: dec_ctrl = ALU_NOR;
                    6'h2A: begin
                        dec_ctrl = ALU_SLT;
                        dec_comp = CMP_LT;
                    end
                    6'h2B: begin
                        dec_ctrl = ALU_SLT;
                        dec_comp = CMP_LTU;
                    end
                    default: begin
                        dec_ctrl    = ALU_AND;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            3'b011: begin
                dec_ctrl = ALU_SLT;
                dec_comp = CMP_LT;
            end
            3'b100: begin
                dec_ctrl = ALU_OR;
                dec_zext = 1'b1;
            end
            3'b101: begin
                dec_ctrl = ALU_AND;
                dec_zext = 1'b1;
            end
            default: dec_ctrl = ALU_ADD;
        endcase
    end

    // Illegal R-type encodings must never reach the register file, so their
    // write enable is suppressed here rather than downstream.
    always_comb begin
        ex_d             = '0;
        ex_d.valid       = bus.id_valid;
        ex_d.rs_data     = bus.id_rs_data;
        ex_d.rt_data     = bus.id_rt_data;
        ex_d.imm         = bus.id_imm;
        ex_d.alusrc      = bus.id_alusrc;
        ex_d.rs          = bus.id_rs;
        ex_d.rt          = bus.id_rt;
        ex_d.wr          = bus.id_wr;
        ex_d.regwrite    = bus.id_valid & bus.id_regwrite & ~dec_illegal;
        ex_d.alu_control = dec_ctrl;
        ex_d.comp        = dec_comp;
        ex_d.illegal     = dec_illegal;
        ex_d.zext        = dec_zext;
    end

    // Flush outranks stall so a squashed instruction cannot be held in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (!bus.stall) begin
            ex_q <= ex_d;
        end
    end

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

`ifdef EX_FWD_EN
    // MEM is the younger producer, so it is checked before WB. Register 0
    // is hard-wired and is never a forwarding target.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (ex_q.rs != '0 && bus.mem_regwrite && bus.mem_rd == ex_q.rs) begin
            fwd_rs = bus.mem_result;
        end else if (ex_q.rs != '0 && bus.wb_regwrite && bus.wb_rd == ex_q.rs) begin
            fwd_rs = bus.wb_data;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (ex_q.rt != '0 && bus.mem_regwrite && bus.mem_rd == ex_q.rt) begin
            fwd_rt = bus.mem_result;
        end else if (ex_q.rt != '0 && bus.wb_regwrite && bus.wb_rd == ex_q.rt) begin
            fwd_rt = bus.wb_data;
        end
    end
`else
    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;
`endif

    logic [DATA_W-1:0] imm_op;

    assign imm_op = ex_q.zext ? {{(DATA_W-16){1'b0}}, ex_q.imm[15:0]} : ex_q.imm;

    assign bus.alu_src1      = fwd_rs;
    assign bus.alu_src2      = ex_q.alusrc ? imm_op : fwd_rt;
    assign bus.alu_control   = ex_q.alu_control;
    assign bus.alu_comp      = ex_q.comp;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_illegal    = ex_q.illegal;
    assign bus.ex_wr         = ex_q.wr;
    assign bus.ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ex_issue_if #(.DATA_W(32), .REG_AW(5)) bus();

    ex_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        id_valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic [5:0]  funct;
        logic        alusrc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic        regwrite;
        logic        mem_regwrite;
        logic        wb_regwrite;
        logic [4:0]  mem_rd;
        logic [4:0]  wb_rd;
        logic [31:0] mem_result;
        logic [31:0] wb_data;
    } stim_t;

    // Architectural contents of the EX slot as the bench understands them.
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        regwrite;
        logic [3:0]  ctrl;
        logic [2:0]  comp;
        logic        use_imm;
        logic        zext;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
    } slot_t;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [2:0]  comp;
        logic        valid;
        logic        regwrite;
        logic        illegal;
        logic [4:0]  wr;
        logic [31:0] store;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t  exp_q[$];
    slot_t slot = '0;

    logic [3:0] rtype_ctrl [logic [5:0]];
    logic [3:0] itype_ctrl [8];
    logic [5:0] legal_f [7];

    initial begin
        rtype_ctrl[6'h20] = 4'b0010;
        rtype_ctrl[6'h22] = 4'b0110;
        rtype_ctrl[6'h24] = 4'b0000;
        rtype_ctrl[6'h25] = 4'b0001;
        rtype_ctrl[6'h27] = 4'b1100;
        rtype_ctrl[6'h2A] = 4'b0111;
        rtype_ctrl[6'h2B] = 4'b0111;
        itype_ctrl = '{4'b0010, 4'b0110, 4'b0000, 4'b0111,
                       4'b0001, 4'b0000, 4'b0010, 4'b0010};
        legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
    end

    function automatic slot_t decode(stim_t s);
        slot_t e = '0;
        e.valid   = s.id_valid;
        e.use_imm = s.alusrc;
        e.imm     = s.imm;
        e.rs      = s.rs;
        e.rt      = s.rt;
        e.wr      = s.wr;
        e.rs_val  = s.rs_data;
        e.rt_val  = s.rt_data;
        if (s.alu_op == 3'b010) begin
            if (rtype_ctrl.exists(s.funct)) begin
                e.ctrl = rtype_ctrl[s.funct];
                e.comp = (s.funct == 6'h2B) ? 3'b101 : 3'b000;
            end else begin
                e.ctrl    = 4'b0000;
                e.illegal = 1'b1;
            end
        end else begin
            e.ctrl = itype_ctrl[s.alu_op];
            e.zext = (s.alu_op == 3'b100) || (s.alu_op == 3'b101);
        end
        e.regwrite = s.id_valid && s.regwrite && !e.illegal;
        return e;
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] latched, stim_t s);
`ifdef EX_FWD_EN
        if (r != 0 && s.mem_regwrite && s.mem_rd == r) return s.mem_result;
        if (r != 0 && s.wb_regwrite && s.wb_rd == r) return s.wb_data;
`endif
        return latched;
    endfunction

    function automatic exp_t outputs(slot_t e, stim_t s);
        exp_t o;
        logic [31:0] rt_now;
        rt_now     = fwd(e.rt, e.rt_val, s);
        o.src1     = fwd(e.rs, e.rs_val, s);
        o.src2     = !e.use_imm ? rt_now : (e.zext ? (e.imm & 32'h0000FFFF) : e.imm);
        o.ctrl     = e.ctrl;
        o.comp     = e.comp;
        o.valid    = e.valid;
        o.regwrite = e.regwrite;
        o.illegal  = e.illegal;
        o.wr       = e.wr;
        o.store    = rt_now;
        return o;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t instr(logic [2:0] op, logic [5:0] fn, logic [4:0] rs,
                                    logic [31:0] rsd, logic [4:0] rt, logic [31:0] rtd,
                                    logic alusrc, logic [31:0] imm);
        stim_t s = idle();
        s.id_valid = 1'b1;
        s.regwrite = 1'b1;
        s.alu_op   = op;
        s.funct    = fn;
        s.rs       = rs;
        s.rs_data  = rsd;
        s.rt       = rt;
        s.rt_data  = rtd;
        s.alusrc   = alusrc;
        s.imm      = imm;
        s.wr       = 5'd9;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n        = ($urandom_range(0, 49) != 0);
        s.stall        = ($urandom_range(0, 4) == 0);
        s.flush        = ($urandom_range(0, 9) == 0);
        s.id_valid     = ($urandom_range(0, 7) != 0);
        s.rs_data      = $urandom;
        s.rt_data      = $urandom;
        s.imm          = $urandom;
        s.alu_op       = 3'($urandom_range(0, 7));
        s.funct        = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 6)]
                                                     : 6'($urandom_range(0, 63));
        s.alusrc       = 1'($urandom_range(0, 1));
        s.rs           = 5'($urandom_range(0, 7));
        s.rt           = 5'($urandom_range(0, 7));
        s.wr           = 5'($urandom_range(0, 31));
        s.regwrite     = 1'($urandom_range(0, 1));
        s.mem_regwrite = 1'($urandom_range(0, 1));
        s.wb_regwrite  = 1'($urandom_range(0, 1));
        s.mem_rd       = 5'($urandom_range(0, 7));
        s.wb_rd        = 5'($urandom_range(0, 7));
        s.mem_result   = $urandom;
        s.wb_data      = $urandom;
        return s;
    endfunction

    task automatic apply(stim_t s);
        @(negedge clk);
        rst_n            = s.rst_n;
        bus.stall        = s.stall;
        bus.flush        = s.flush;
        bus.id_valid     = s.id_valid;
        bus.id_rs_data   = s.rs_data;
        bus.id_rt_data   = s.rt_data;
        bus.id_imm       = s.imm;
        bus.id_alu_op    = s.alu_op;
        bus.id_funct     = s.funct;
        bus.id_alusrc    = s.alusrc;
        bus.id_rs        = s.rs;
        bus.id_rt        = s.rt;
        bus.id_wr        = s.wr;
        bus.id_regwrite  = s.regwrite;
        bus.mem_regwrite = s.mem_regwrite;
        bus.wb_regwrite  = s.wb_regwrite;
        bus.mem_rd       = s.mem_rd;
        bus.wb_rd        = s.wb_rd;
        bus.mem_result   = s.mem_result;
        bus.wb_data      = s.wb_data;
        if (!s.rst_n || s.flush) slot = '0;
        else if (!s.stall)       slot = decode(s);
        exp_q.push_back(outputs(slot, s));
    endtask

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL cyc=%0d %s got=%h expected=%h", cyc, name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("alu_src1",      bus.alu_src1,             e.src1);
                cmp("alu_src2",      bus.alu_src2,             e.src2);
                cmp("alu_control",   32'(bus.alu_control),     32'(e.ctrl));
                cmp("alu_comp",      32'(bus.alu_comp),        32'(e.comp));
                cmp("ex_valid",      32'(bus.ex_valid),        32'(e.valid));
                cmp("ex_regwrite",   32'(bus.ex_regwrite),     32'(e.regwrite));
                cmp("ex_illegal",    32'(bus.ex_illegal),      32'(e.illegal));
                cmp("ex_wr",         32'(bus.ex_wr),           32'(e.wr));
                cmp("ex_store_data", bus.ex_store_data,        e.store);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        stim_t s;
        // Reset held with random ID traffic, then an ADD right after release.
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.rst_n = 1'b0;
            apply(s);
        end
        apply(instr(3'b010, 6'h20, 5'd5, 32'd7, 5'd6, 32'd9, 1'b0, 32'h0));

        for (int i = 0; i < 7; i++)
            apply(instr(3'b010, legal_f[i], 5'd1, 32'h100 + 32'(i), 5'd2, 32'h200, 1'b0, 32'h0));
        apply(instr(3'b010, 6'h08, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0));

        // Forwarding priority and register-0 exclusion.
        apply(instr(3'b010, 6'h20, 5'd3, 32'hAA, 5'd4, 32'hBB, 1'b0, 32'h0));
        s = idle();
        s.stall = 1'b1;
        s.mem_regwrite = 1'b1; s.mem_rd = 5'd3; s.mem_result = 32'h11;
        s.wb_regwrite  = 1'b1; s.wb_rd  = 5'd3; s.wb_data    = 32'h22;
        apply(s);
        s.mem_regwrite = 1'b0;
        apply(s);
        s = instr(3'b010, 6'h20, 5'd0, 32'h55, 5'd4, 32'hBB, 1'b0, 32'h0);
        s.mem_regwrite = 1'b1; s.mem_rd = 5'd0; s.mem_result = 32'h11;
        apply(s);

        // Zero- versus sign-extended immediates.
        apply(instr(3'b100, 6'h00, 5'd1, 32'h1, 5'd2, 32'h2, 1'b1, 32'hFFFF8000));
        apply(instr(3'b000, 6'h00, 5'd1, 32'h1, 5'd2, 32'h2, 1'b1, 32'hFFFF8000));

        // Three-cycle stall with a late WB value for rt on the second cycle.
        apply(instr(3'b010, 6'h22, 5'd5, 32'h10, 5'd4, 32'h20, 1'b0, 32'h0));
        s = rand_stim();
        s.rst_n = 1'b1; s.stall = 1'b1; s.flush = 1'b0;
        s.mem_regwrite = 1'b0; s.wb_regwrite = 1'b0;
        apply(s);
        s.wb_regwrite = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h99;
        apply(s);
        apply(s);

        // Stall and flush together squash the slot.
        s = instr(3'b010, 6'h25, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0);
        apply(s);
        s.stall = 1'b1; s.flush = 1'b1;
        apply(s);

        for (int i = 0; i < 400; i++) apply(rand_stim());

        apply(idle());
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
